// File: rtl/activation_sequencer.sv
// activation_sequencer
// Shares one activation unit (LUT + interpolator) across all neurons of a
// layer. A packed vector of pre-activations is latched, fed to the unit one
// sample per cycle, and the results are reassembled into a packed output
// vector. The output is presented with a valid/ready handshake.
// A tag pipeline matching the unit latency records which neuron each
// returning result belongs to.
module activation_sequencer #(
    parameter int NUM_NEURONS = 4,
    parameter int DATA_W      = 8,
    parameter int ACT_LAT     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_NEURONS*DATA_W-1:0] in_z,
    output logic [DATA_W-1:0]             act_z,
    output logic                          act_issue,
    input  logic [DATA_W-1:0]             act_a,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_NEURONS*DATA_W-1:0] out_a,
    output logic                          busy
);

    localparam int              IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   issue_idx_q;
    logic [IDX_W-1:0]   issue_idx_d;
    logic               load_z;

    // Latched input vector and collected results, one entry per neuron.
    logic [DATA_W-1:0]  in_z_w [NUM_NEURONS];
    logic [DATA_W-1:0]  z_q    [NUM_NEURONS];
    logic [DATA_W-1:0]  a_q    [NUM_NEURONS];

    // Result returning from the unit this cycle and the neuron it belongs to.
    logic               cap_valid;
    logic [IDX_W-1:0]   cap_idx;

    // Unpack the input vector and pack the result vector, lane by lane.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_lane
            assign in_z_w[gi]                   = in_z[gi*DATA_W +: DATA_W];
            assign out_a[gi*DATA_W +: DATA_W]   = a_q[gi];
        end
    endgenerate

    // Tag path: a combinational unit returns its result in the issue cycle,
    // a pipelined one returns it ACT_LAT cycles later, tagged by a shift
    // register of (valid, index) pairs so that idle cycles are never captured.
    generate
        if (ACT_LAT == 0) begin : g_no_lat
            assign cap_valid = (state_q == ST_ISSUE);
            assign cap_idx   = issue_idx_q;
        end else begin : g_lat
            logic [ACT_LAT-1:0] tag_valid_q;
            logic [IDX_W-1:0]   tag_idx_q [ACT_LAT];

            // Shift tags along with the unit pipeline; reset flushes in-flight tags.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_valid_q <= '0;
                    for (int k = 0; k < ACT_LAT; k++) begin
                        tag_idx_q[k] <= '0;
                    end
                end else begin
                    tag_valid_q[0] <= (state_q == ST_ISSUE);
                    tag_idx_q[0]   <= issue_idx_q;
                    for (int k = 1; k < ACT_LAT; k++) begin
                        tag_valid_q[k] <= tag_valid_q[k-1];
                        tag_idx_q[k]   <= tag_idx_q[k-1];
                    end
                end
            end

            assign cap_valid = tag_valid_q[ACT_LAT-1];
            assign cap_idx   = tag_idx_q[ACT_LAT-1];
        end
    endgenerate

    // Next-state, issue index and handshake/unit outputs.
    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        load_z      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        act_issue   = 1'b0;
        act_z       = '0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_z      = 1'b1;
                    issue_idx_d = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                act_issue = 1'b1;
                act_z     = z_q[issue_idx_q];
                if (issue_idx_q == LAST_IDX) begin
                    // Index holds at the last neuron rather than wrapping.
                    state_d = (ACT_LAT > 0) ? ST_DRAIN : ST_DONE;
                end else begin
                    issue_idx_d = issue_idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Results return in issue order, so the last index closes the vector.
                if (cap_valid && (cap_idx == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register, issue index and input vector latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_idx_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                z_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            if (load_z) begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    z_q[i] <= in_z_w[i];
                end
            end
        end
    end

    // Write each returning activation into its neuron's slot of the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (cap_valid && (cap_idx == IDX_W'(i))) begin
                    a_q[i] <= act_a;
                end
            end
        end
    end

endmodule

// File: tb/tb_activation_sequencer.sv
// Bench for activation_sequencer: two instances (unit latency 0 and 2),
// each driven by a model activation unit a = z + 1 saturating at 127.
module tb_activation_sequencer;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [VW-1:0] in_z      [2];
    logic [W-1:0]  act_z     [2];
    logic          act_issue [2];
    logic [W-1:0]  act_a     [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [VW-1:0] out_a     [2];
    logic          busy      [2];

    int checks = 0;
    int errors = 0;
    logic [VW-1:0] exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] z);
        if (z == 8'h7f) return z;
        return z + W'(1);
    endfunction

    function automatic logic [VW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = 2 * gi;
            activation_sequencer #(
                .NUM_NEURONS(N),
                .DATA_W     (W),
                .ACT_LAT    (LAT)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_z      (in_z[gi]),
                .act_z     (act_z[gi]),
                .act_issue (act_issue[gi]),
                .act_a     (act_a[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_a     (out_a[gi]),
                .busy      (busy[gi])
            );
            if (LAT == 0) begin : g_comb
                assign act_a[gi] = sat_inc(act_z[gi]);
            end else begin : g_pipe
                logic [W-1:0] pipe [LAT];
                always @(posedge clk) begin
                    pipe[0] <= act_z[gi];
                    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
                end
                assign act_a[gi] = sat_inc(pipe[LAT-1]);
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({in_ready[s], out_valid[s], busy[s], act_issue[s]} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_ctrl dut%0d: got rdy/ov/busy/iss=%b required 1000", s,
                         {in_ready[s], out_valid[s], busy[s], act_issue[s]});
            end
            checks++;
            if ({act_z[s], out_a[s]} !== '0) begin
                errors++;
                $display("FAIL reset_data dut%0d: got act_z=%h out_a=%h required 0", s, act_z[s], out_a[s]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    // One vector end to end, checking issue order, drain, latency and result.
    task automatic test_single(input int sel);
        int lat = 2 * sel;
        int cyc;
        logic [VW-1:0] v = pack4(-128, 0, 5, 127);
        logic [VW-1:0] prev;
        logic [VW-1:0] ev;
        exp_q.push_back(pack4(-127, 1, 6, 127));
        prev = out_a[sel];
        out_ready[sel] = 1'b0;
        in_z[sel] = v;
        in_valid[sel] = 1'b1;
        checks++;
        if (in_ready[sel] !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready dut%0d: got %b required 1", sel, in_ready[sel]);
        end
        tick();
        in_valid[sel] = 1'b0;
        cyc = 1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({act_issue[sel], act_z[sel]} !== {1'b1, lane(v, i)}) begin
                errors++;
                $display("FAIL single_issue%0d dut%0d: got iss=%b z=%h required iss=1 z=%h",
                         i, sel, act_issue[sel], act_z[sel], lane(v, i));
            end
            if (cyc <= lat + 1) begin
                checks++;
                if (out_a[sel] !== prev) begin
                    errors++;
                    $display("FAIL single_early_capture dut%0d cyc%0d: got %h required %h", sel, cyc, out_a[sel], prev);
                end
            end
            tick();
            cyc++;
        end
        for (int d = 0; d < lat; d++) begin
            checks++;
            if ({act_issue[sel], act_z[sel], out_valid[sel], busy[sel]} !== {1'b0, W'(0), 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL single_drain dut%0d: got iss=%b z=%h ov=%b busy=%b required 0 00 0 1",
                         sel, act_issue[sel], act_z[sel], out_valid[sel], busy[sel]);
            end
            tick();
            cyc++;
        end
        while (!out_valid[sel] && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != N + lat + 1 || out_valid[sel] !== 1'b1) begin
            errors++;
            $display("FAIL single_latency dut%0d: got %0d cycles required %0d", sel, cyc, N + lat + 1);
        end
        ev = exp_q.pop_front();
        $display("txn single dut%0d out_a=%h expected=%h", sel, out_a[sel], ev);
        checks++;
        if (out_a[sel] !== ev) begin
            errors++;
            $display("FAIL single_out_a dut%0d: got %h required %h", sel, out_a[sel], ev);
        end
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        checks++;
        if ({out_valid[sel], in_ready[sel]} !== 2'b01) begin
            errors++;
            $display("FAIL single_release dut%0d: got ov/rdy=%b required 01", sel, {out_valid[sel], in_ready[sel]});
        end
    endtask

    // Output back-pressure with a new vector waiting at the input.
    task automatic test_hold(input int sel);
        int cyc;
        logic [VW-1:0] v1 = pack4(10, -20, 30, -40);
        logic [VW-1:0] v2 = pack4(100, -100, 126, -1);
        logic [VW-1:0] ev;
        exp_q.push_back(pack4(11, -19, 31, -39));
        in_z[sel] = v1;
        in_valid[sel] = 1'b1;
        tick();
        in_valid[sel] = 1'b0;
        cyc = 1;
        while (!out_valid[sel] && cyc < 40) begin
            tick();
            cyc++;
        end
        in_z[sel] = v2;
        in_valid[sel] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({out_valid[sel], in_ready[sel], act_issue[sel]} !== 3'b100 || out_a[sel] !== exp_q[0]) begin
                errors++;
                $display("FAIL hold_cycle%0d dut%0d: got ov/rdy/iss=%b out_a=%h required 100 out_a=%h",
                         c, sel, {out_valid[sel], in_ready[sel], act_issue[sel]}, out_a[sel], exp_q[0]);
            end
            tick();
        end
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        checks++;
        if ({out_valid[sel], in_ready[sel]} !== 2'b01) begin
            errors++;
            $display("FAIL hold_idle dut%0d: got ov/rdy=%b required 01", sel, {out_valid[sel], in_ready[sel]});
        end
        ev = exp_q.pop_front();
        $display("txn hold dut%0d out_a=%h expected=%h", sel, out_a[sel], ev);
        checks++;
        if (out_a[sel] !== ev) begin
            errors++;
            $display("FAIL hold_out_a dut%0d: got %h required %h", sel, out_a[sel], ev);
        end
        exp_q.push_back(pack4(101, -99, 127, 0));
        tick();
        in_valid[sel] = 1'b0;
        checks++;
        if ({act_issue[sel], act_z[sel]} !== {1'b1, lane(v2, 0)}) begin
            errors++;
            $display("FAIL hold_second_issue dut%0d: got iss=%b z=%h required iss=1 z=%h",
                     sel, act_issue[sel], act_z[sel], lane(v2, 0));
        end
        cyc = 1;
        while (!out_valid[sel] && cyc < 40) begin
            tick();
            cyc++;
        end
        ev = exp_q.pop_front();
        $display("txn hold2 dut%0d out_a=%h expected=%h", sel, out_a[sel], ev);
        checks++;
        if (out_valid[sel] !== 1'b1 || out_a[sel] !== ev) begin
            errors++;
            $display("FAIL hold2_out_a dut%0d: got ov=%b out_a=%h required ov=1 out_a=%h", sel, out_valid[sel], out_a[sel], ev);
        end
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
    endtask

    // Two vectors streamed with out_ready held high.
    task automatic test_back_to_back(input int sel);
        int lat = 2 * sel;
        int cyc = 0;
        int nsent = 0;
        int nrecv = 0;
        int hs_t [2];
        logic hs;
        logic ov;
        logic [VW-1:0] vecs [2];
        logic [VW-1:0] exps [2];
        logic [VW-1:0] ev;
        vecs[0] = pack4(1, -1, 64, -64);
        exps[0] = pack4(2, 0, 65, -63);
        vecs[1] = pack4(-128, 127, 0, 50);
        exps[1] = pack4(-127, 127, 1, 51);
        hs_t[0] = 0;
        hs_t[1] = 0;
        out_ready[sel] = 1'b1;
        in_z[sel] = vecs[0];
        in_valid[sel] = 1'b1;
        while (nrecv < 2 && cyc < 100) begin
            hs = in_valid[sel] && in_ready[sel];
            ov = out_valid[sel];
            if (ov) begin
                ev = exp_q.pop_front();
                $display("txn b2b dut%0d out_a=%h expected=%h", sel, out_a[sel], ev);
                checks++;
                if (out_a[sel] !== ev) begin
                    errors++;
                    $display("FAIL b2b_out_a%0d dut%0d: got %h required %h", nrecv, sel, out_a[sel], ev);
                end
                nrecv++;
            end
            tick();
            cyc++;
            if (hs && nsent < 2) begin
                exp_q.push_back(exps[nsent]);
                hs_t[nsent] = cyc;
                nsent++;
                if (nsent == 1) in_z[sel] = vecs[1];
                else            in_valid[sel] = 1'b0;
            end
        end
        out_ready[sel] = 1'b0;
        in_valid[sel] = 1'b0;
        checks++;
        if (nrecv != 2) begin
            errors++;
            $display("FAIL b2b_timeout dut%0d: got %0d outputs required 2", sel, nrecv);
        end
        checks++;
        if (hs_t[1] - hs_t[0] != N + lat + 2) begin
            errors++;
            $display("FAIL b2b_period dut%0d: got %0d required %0d", sel, hs_t[1] - hs_t[0], N + lat + 2);
        end
    endtask

    // Reset during issue, then a clean vector with no stale captures.
    task automatic test_reset_mid(input int sel);
        int lat = 2 * sel;
        int cyc;
        logic [VW-1:0] v = pack4(1, 2, 3, 4);
        logic [VW-1:0] ev;
        in_z[sel] = pack4(-5, -6, -7, -8);
        in_valid[sel] = 1'b1;
        tick();
        in_valid[sel] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if ({in_ready[sel], out_valid[sel], busy[sel], act_issue[sel]} !== 4'b1000 ||
            {act_z[sel], out_a[sel]} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs dut%0d: got rdy/ov/busy/iss=%b z=%h out_a=%h required 1000 0 0",
                     sel, {in_ready[sel], out_valid[sel], busy[sel], act_issue[sel]}, act_z[sel], out_a[sel]);
        end
        tick();
        rst = 1'b0;
        exp_q.push_back(pack4(2, 3, 4, 5));
        in_z[sel] = v;
        in_valid[sel] = 1'b1;
        tick();
        in_valid[sel] = 1'b0;
        cyc = 1;
        while (!out_valid[sel] && cyc < 40) begin
            if (cyc <= lat + 1) begin
                checks++;
                if (out_a[sel] !== '0) begin
                    errors++;
                    $display("FAIL midrst_stale dut%0d cyc%0d: got %h required 0", sel, cyc, out_a[sel]);
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (cyc != N + lat + 1) begin
            errors++;
            $display("FAIL midrst_latency dut%0d: got %0d required %0d", sel, cyc, N + lat + 1);
        end
        ev = exp_q.pop_front();
        $display("txn midrst dut%0d out_a=%h expected=%h", sel, out_a[sel], ev);
        checks++;
        if (out_a[sel] !== ev) begin
            errors++;
            $display("FAIL midrst_out_a dut%0d: got %h required %h", sel, out_a[sel], ev);
        end
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
    endtask

    // out_ready outside DONE must not disturb anything.
    task automatic test_out_ready_ignored(input int sel);
        int lat = 2 * sel;
        int cyc;
        logic [VW-1:0] v = pack4(7, 8, 9, 10);
        logic [VW-1:0] ev;
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        checks++;
        if ({in_ready[sel], busy[sel], out_valid[sel]} !== 3'b100) begin
            errors++;
            $display("FAIL ign_idle dut%0d: got rdy/busy/ov=%b required 100", sel, {in_ready[sel], busy[sel], out_valid[sel]});
        end
        exp_q.push_back(pack4(8, 9, 10, 11));
        in_z[sel] = v;
        in_valid[sel] = 1'b1;
        tick();
        in_valid[sel] = 1'b0;
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        cyc = 2;
        checks++;
        if ({act_issue[sel], busy[sel], act_z[sel]} !== {2'b11, lane(v, 1)}) begin
            errors++;
            $display("FAIL ign_issue dut%0d: got iss/busy=%b z=%h required 11 z=%h",
                     sel, {act_issue[sel], busy[sel]}, act_z[sel], lane(v, 1));
        end
        while (!out_valid[sel] && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != N + lat + 1) begin
            errors++;
            $display("FAIL ign_latency dut%0d: got %0d required %0d", sel, cyc, N + lat + 1);
        end
        tick();
        tick();
        ev = exp_q.pop_front();
        $display("txn ign dut%0d out_a=%h expected=%h", sel, out_a[sel], ev);
        checks++;
        if (out_valid[sel] !== 1'b1 || out_a[sel] !== ev) begin
            errors++;
            $display("FAIL ign_out dut%0d: got ov=%b out_a=%h required ov=1 out_a=%h", sel, out_valid[sel], out_a[sel], ev);
        end
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_z[s]      = '0;
            out_ready[s] = 1'b0;
        end
        test_reset();
        test_single(0);
        test_single(1);
        test_hold(0);
        test_hold(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid(1);
        test_out_ready_ignored(0);
        test_out_ready_ignored(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/activation_sequencer.md
Name: activation_sequencer

Overview:
- Time-multiplexes one shared activation-function unit (LUT + linear interpolator, 8-bit signed in/out) across all neurons of a layer.
- Accepts a packed vector of pre-activation values z and issues them to the unit one per cycle.
- Collects the returned activations a into a packed output vector and presents it with a valid/ready handshake.
- Sits between a layer's weighted-sum stage and the next layer's input.

Parameters:
- NUM_NEURONS, 4, number of z values per vector (2..16).
- DATA_W, 8, signed width of z and a.
- ACT_LAT, 0, pipeline latency of the shared activation unit in cycles (0 = combinational, range 0..3).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  sequencer can accept a vector.
- in_z  in  NUM_NEURONS*DATA_W  packed z; neuron i at bits [i*DATA_W +: DATA_W].
- act_z  out  DATA_W  z value driven to the shared activation unit.
- act_issue  out  1  act_z carries a real sample this cycle.
- act_a  in  DATA_W  activation result from the unit, ACT_LAT cycles after issue.
- out_valid  out  1  out_a complete and stable.
- out_ready  in  1  consumer accepts out_a.
- out_a  out  NUM_NEURONS*DATA_W  packed activations, same packing as in_z.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State IDLE; in_ready=1; out_valid=0; busy=0; act_issue=0.
  - act_z=0; out_a=0; all indices and tag pipeline cleared.
- State machine (IDLE, ISSUE, DRAIN, DONE):
  - IDLE: in_ready=1. On in_valid, latch in_z into z_reg, set issue_idx=0, go to ISSUE.
  - ISSUE: act_z = z_reg[issue_idx], act_issue=1, issue_idx increments each cycle.
    - After issuing index NUM_NEURONS-1: go to DRAIN if ACT_LAT>0, otherwise to DONE.
  - DRAIN: act_issue=0, act_z=0. Wait until the last tag is captured, then go to DONE.
  - DONE: out_valid=1 and out_a held stable. On out_ready, go to IDLE; out_valid drops next cycle.
- Capture path:
  - A tag shift register of depth ACT_LAT carries (valid, index) for each issued sample.
  - When a tag exits, act_a is written into out_a[index].
  - With ACT_LAT=0, act_a is captured in the same cycle as the issue.
  - Capture is in strict issue order; each index is written exactly once per vector.
- Latency:
  - Input handshake cycle to first issue: 1 cycle.
  - Input handshake to out_valid: NUM_NEURONS + ACT_LAT + 1 cycles.
  - Back-to-back throughput: one vector per NUM_NEURONS + ACT_LAT + 2 cycles, with out_ready held high.
- Handshake rules:
  - in_ready is high only in IDLE. in_valid outside IDLE is ignored; the producer must hold its data.
  - out_a changes only while out_valid=0. Once asserted, out_valid stays high until out_ready is sampled high.
  - The input and output handshakes are never accepted in the same cycle; IDLE is always visited between vectors.
- Arithmetic: no arithmetic on data; values pass through unmodified and stay signed DATA_W. Index counters are $clog2(NUM_NEURONS) bits wide; issue_idx does not wrap within a vector.
- act_z and act_issue are 0 whenever the state is not ISSUE.
- Reset mid-operation: everything returns immediately to reset values. Partial results are discarded, and the in-flight tags are flushed so late act_a values are never captured.
- out_ready while not in DONE is ignored.

Test Plan:
- Bench model for the activation unit: a = z + 1 (saturating at 127), delayed ACT_LAT cycles.
- Single vector, NUM_NEURONS=4, ACT_LAT=0, in_z = {-128, 0, 5, 127} for neurons 0..3 -> act_z sequence -128, 0, 5, 127 on cycles 1..4; out_a = {-127, 1, 6, 127}; out_valid asserted 5 cycles after the handshake.
- ACT_LAT=2, same vector -> DRAIN lasts 2 cycles; out_valid at cycle 7; out_a identical to the ACT_LAT=0 case; no capture occurs while the tag is invalid.
- out_ready held low for 10 cycles in DONE, with in_valid high and a new in_z -> out_valid and out_a stable throughout, in_ready=0; the new vector is accepted only after out_ready, one cycle after IDLE is re-entered.
- Two vectors back-to-back with out_ready=1 -> second vector's results are not contaminated by the first; period is NUM_NEURONS + ACT_LAT + 2 cycles.
- rst asserted mid-ISSUE (after 2 issues, ACT_LAT=2) -> outputs immediately at reset values; the following vector {1,2,3,4} yields out_a = {2,3,4,5} with no stale writes.
- out_ready pulsed in IDLE and ISSUE -> no effect on state or on out_valid.
